dc_pwm_driver: RTL and testbench

DC_PWM_DRIVER -- requirements
Module: dc_pwm_driver

---
 rtl/dc_pwm_driver.sv | 118 +++++++++++
 tb/tb_dc_pwm_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_pwm_driver.sv
// DC motor PWM driver: 8-phase PWM period of 8*PRESCALE clocks, with duty level taken at period boundaries.
// Latency: pwm_out is registered one clock after phase/duty; period_start and at_target are combinational.
// Backpressure: none; dc_control is only sampled at a boundary, and en winds the drive down to idle when low.
// Optional build macro DC_PWM_SOFT_RAMP_EN: duty_active moves one step per boundary instead of jumping.
module dc_pwm_driver #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] dc_control,
  output logic       pwm_out,
  output logic       period_start,
  output logic [2:0] duty_active,
  output logic       at_target
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pre_cnt;
  logic [2:0] phase;
  logic       tick;
  logic       boundary;
  logic [2:0] target;
  logic [2:0] duty_nxt;

  // Counters only run outside IDLE, so a boundary can never fire while idle.
  assign tick         = (state != IDLE) && (pre_cnt == PRE_MAX);
  assign boundary     = tick && (phase == 3'd7);
  assign period_start = boundary;

  // Winding down always aims for zero drive.
  assign target    = (state == RUN) ? dc_control : 3'd0;
  assign at_target = (duty_active == target);

  // Duty level to apply at the coming boundary.
  always_comb begin
    duty_nxt = duty_active;
`ifdef DC_PWM_SOFT_RAMP_EN
    if (duty_active < target) begin
      duty_nxt = duty_active + 3'd1;
    end else if (duty_active > target) begin
      duty_nxt = duty_active - 3'd1;
    end
`else
    duty_nxt = target;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; re-enable in STOP wins over dropping to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN:  if (!en) state_nxt = STOP;
      STOP: begin
        if (en) begin
          state_nxt = RUN;
        end else if (boundary && (duty_nxt == 3'd0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Prescale and phase counters; held at zero in IDLE so RUN entry starts a fresh period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= 8'd0;
      phase   <= 3'd0;
    end else if (state == IDLE) begin
      pre_cnt <= 8'd0;
      phase   <= 3'd0;
    end else if (tick) begin
      pre_cnt <= 8'd0;
      phase   <= phase + 3'd1;
    end else begin
      pre_cnt <= pre_cnt + 8'd1;
    end
  end

  // Duty level changes only at a period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_active <= 3'd0;
    end else if (boundary) begin
      duty_active <= duty_nxt;
    end
  end

  // Registered drive: high for the first duty_active phases of each period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (state != IDLE) && (phase < duty_active);
    end
  end

endmodule

// File: tb/tb_dc_pwm_driver.sv
// Directed bench for dc_pwm_driver with PRESCALE=4 (32-clock PWM period).
// Inputs change and outputs are sampled on the falling clock edge.
// Covers either build of the soft-ramp option.
module tb_dc_pwm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] dc_control;
  logic       pwm_out;
  logic       period_start;
  logic [2:0] duty_active;
  logic       at_target;

  int compared   = 0;
  int mismatched = 0;
  int n;
  int hi;
  int psc;
  int lastps;

  dc_pwm_driver #(.PRESCALE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .dc_control   (dc_control),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_active  (duty_active),
    .at_target    (at_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Steps until period_start is seen; n = samples taken (-1 if none within bound), hi = pwm high samples.
  task automatic wait_ps(output int cnt, output int high);
    cnt  = -1;
    high = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) high++;
      if (period_start === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Samples one full 32-clock period starting from a boundary cycle.
  task automatic count_period(output int high, output int pscnt, output int last);
    high  = 0;
    pscnt = 0;
    last  = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) high++;
      if (period_start === 1'b1) pscnt++;
      if (i == 32) last = (period_start === 1'b1) ? 1 : 0;
    end
  endtask

  // Confirms the driver sits idle: no drive and no period boundaries.
  task automatic idle_check(input string tag);
    int h = 0;
    int p = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pwm_out !== 1'b0) h++;
      if (period_start !== 1'b0) p++;
    end
    check({tag, "_pwm"}, h, 0);
    check({tag, "_ps"}, p, 0);
    check({tag, "_duty"}, duty_active, 0);
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    dc_control = 3'd0;
    step(2);
    check("rst_pwm", pwm_out, 0);
    check("rst_ps", period_start, 0);
    check("rst_duty", duty_active, 0);
    check("rst_at_target", at_target, 1);

`ifdef DC_PWM_SOFT_RAMP_EN
    // Ramp up 0 -> 7 one step per boundary.
    rst = 1'b0;
    en  = 1'b1;
    step(1);
    dc_control = 3'd7;
    wait_ps(n, hi);
    check("first_ps", n, 31);
    for (int v = 1; v <= 7; v++) begin
      step(1);
      check("ramp_up_duty", duty_active, v);
      check("ramp_up_at_target", at_target, (v == 7) ? 1 : 0);
      wait_ps(n, hi);
      check("ramp_up_period", n, 31);
    end
    step(1);
    check("ramp_hold", duty_active, 7);
    dc_control = 3'd4;
    for (int v = 6; v >= 4; v--) begin
      wait_ps(n, hi);
      check("ramp_dn_period", n, 31);
      step(1);
      check("ramp_dn_duty", duty_active, v);
    end
    // Wind down from 4, re-enable at 2.
    en = 1'b0;
    step(1);
    check("stop_at_target", at_target, 0);
    for (int v = 3; v >= 2; v--) begin
      wait_ps(n, hi);
      check("stop_period", n, (v == 3) ? 30 : 31);
      step(1);
      check("stop_duty", duty_active, v);
    end
    en = 1'b1;
    step(1);
    check("resume_at_target", at_target, 0);
    wait_ps(n, hi);
    check("resume_no_restart", n, 30);
    step(1);
    check("resume_duty3", duty_active, 3);
    wait_ps(n, hi);
    check("resume_period", n, 31);
    step(1);
    check("resume_duty4", duty_active, 4);
    check("resume_at_target4", at_target, 1);
    en = 1'b0;
    step(1);
    for (int v = 3; v >= 0; v--) begin
      wait_ps(n, hi);
      check("wind_period", n, (v == 3) ? 30 : 31);
      step(1);
      check("wind_duty", duty_active, v);
    end
    idle_check("wind_idle");
`else
    // First period after RUN entry, then duty 5 / 7 / 0 patterns.
    rst        = 1'b0;
    en         = 1'b1;
    dc_control = 3'd5;
    wait_ps(n, hi);
    check("first_ps", n, 32);
    check("first_pwm", hi, 0);
    check("first_at_target", at_target, 0);
    count_period(hi, psc, lastps);
    check("duty5_pwm", hi, 20);
    check("duty5_ps_cnt", psc, 1);
    check("duty5_ps_last", lastps, 1);
    check("duty5_duty", duty_active, 5);
    check("duty5_at_target", at_target, 1);
    dc_control = 3'd7;
    count_period(hi, psc, lastps);
    check("duty7_pwm", hi, 28);
    check("duty7_duty", duty_active, 7);
    dc_control = 3'd0;
    count_period(hi, psc, lastps);
    check("duty0_pwm", hi, 0);
    check("duty0_at_target", at_target, 1);
    // Mid-period dc_control changes are ignored until the boundary.
    dc_control = 3'd2;
    step(1);
    check("mid_duty_a", duty_active, 2);
    dc_control = 3'd3;
    step(5);
    dc_control = 3'd6;
    step(1);
    check("mid_duty_b", duty_active, 2);
    check("mid_at_target", at_target, 0);
    step(5);
    dc_control = 3'd3;
    wait_ps(n, hi);
    check("mid_period", n, 20);
    step(1);
    check("mid_duty_c", duty_active, 3);
    check("mid_at_target_c", at_target, 1);
    // Brief en drop mid-period must not restart the period.
    step(7);
    en = 1'b0;
    step(1);
    check("blip_stop_at_target", at_target, 0);
    en = 1'b1;
    step(1);
    check("blip_run_at_target", at_target, 1);
    wait_ps(n, hi);
    check("blip_no_restart", n, 22);
    step(1);
    check("blip_duty", duty_active, 3);
    // Wind down: no ramp reaches IDLE at the first boundary.
    en = 1'b0;
    step(1);
    wait_ps(n, hi);
    check("stop_period", n, 30);
    step(1);
    check("stop_duty", duty_active, 0);
    check("stop_at_target", at_target, 1);
    idle_check("stop_idle");
`endif

    // Restart from IDLE, then reset mid-period while driving high.
    dc_control = 3'd4;
    en         = 1'b1;
    wait_ps(n, hi);
    check("restart_ps", n, 32);
    step(2);
    check("pre_rst_pwm", pwm_out, 1);
    rst = 1'b1;
    #1;
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_duty", duty_active, 0);
    check("async_rst_ps", period_start, 0);
    check("async_rst_at_target", at_target, 1);
    step(1);
    check("held_rst_pwm", pwm_out, 0);
    rst = 1'b0;
    wait_ps(n, hi);
    check("post_rst_ps", n, 32);
    check("post_rst_pwm", hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
